lock_code_tx: RTL
=================

# lock_code_tx

Serial code transmitter for the safety-lock datapath. Accepts a parallel code word through a ready/start handshake, shifts it out MSB-first on a ser_valid/ser_data serial link toward the lock checker, waits for the checker's pass/fail verdict (with timeout), and reports the outcome. After MAX_FAILS consecutive failed attempts it enforces a lockout period before accepting another code.

## Interface
- CODE_W, 4: code word width in bits (≥1)
- GAP, 2: idle cycles with ser_valid low after each attempt (≥1)
- TIMEOUT, 8: cycles to wait for a verdict after the last bit (≥1)
- MAX_FAILS, 3: consecutive fails/timeouts that trigger lockout (≥1)
- LOCK_CYCLES, 64: lockout duration in cycles (≥1)
- clk  input  1  clock, all logic on rising edge
- rstn  input  1  reset, asynchronous, active-low
- code_in  input  CODE_W  code to transmit, sampled on accepted start
- start  input  1  request to send; accepted when start && ready
- ready  output  1  high only in IDLE
- ser_valid  output  1  serial bit valid
- ser_data  output  1  serial bit, MSB first
- res_pass  input  1  checker verdict: code correct (1-cycle pulse)
- res_fail  input  1  checker verdict: code wrong (1-cycle pulse)
- done  output  1  1-cycle pulse, attempt finished
- pass  output  1  valid with done: 1 = accepted
- timeout  output  1  valid with done: 1 = no verdict within TIMEOUT
- locked  output  1  high throughout lockout

## Operation
- States: IDLE, SEND, WAIT_RES, GAP, LOCKOUT.
- IDLE: ready=1, ser_valid=0. On start && ready: latch code_in into shift register, bit index = CODE_W-1, go to SEND.
- SEND: ser_valid=1, ser_data = code[index]; one bit per cycle, no stalls. After bit 0, go to WAIT_RES.
- res_fail sampled in SEND: abort; remaining bits are not sent; verdict = fail; go to GAP. res_pass in SEND is ignored.
- WAIT_RES: ser_valid=0, timeout counter runs from 0. res_fail → verdict fail; res_pass → verdict pass; both in same cycle → fail wins. Counter reaching TIMEOUT with no verdict → verdict timeout. Go to GAP.
- GAP: ser_valid=0 for exactly GAP cycles; done=1 in first GAP cycle only, with pass/timeout reflecting verdict (fail: pass=0, timeout=0). pass/timeout are 0 whenever done=0.
- Fail counter (width clog2(MAX_FAILS+1)): +1 on fail or timeout, cleared on pass; saturates at MAX_FAILS.
- End of GAP: fail counter == MAX_FAILS → LOCKOUT; otherwise → IDLE.
- LOCKOUT: locked=1, ready=0, ser_valid=0 for LOCK_CYCLES cycles; on exit clear fail counter, go to IDLE.
- res_pass/res_fail outside SEND/WAIT_RES are ignored. start outside IDLE is ignored (not queued).
- ser_data is 0 whenever ser_valid=0.

## Timing
- Reset (async assert, sync release): state IDLE, ready=1, ser_valid=0, ser_data=0, done=0, pass=0, timeout=0, locked=0, fail counter 0, shift register 0. Reset mid-frame drops ser_valid immediately.
- start accepted at edge T: ser_valid high for cycles T+1..T+CODE_W; WAIT_RES from T+CODE_W+1.
- Verdict sampled at edge V: done pulse in cycle V+1; ready high again at V+GAP+1 (no lockout).
- Timeout: with no verdict, done(timeout=1) occurs TIMEOUT+1 cycles after the first WAIT_RES cycle.
- Lockout: locked high from V+GAP+1 for LOCK_CYCLES cycles, ready high in the following cycle.
- Back-to-back attempts are separated by ≥ GAP cycles of ser_valid=0, so the checker always sees a valid drop between frames.

## Test plan
- Reset, code_in=4'b1011, start: ser_data 1,0,1,1 on 4 consecutive ser_valid cycles; res_pass 2 cycles later → done=1, pass=1, timeout=0; ready returns after GAP=2.
- code_in=4'b1011, res_fail asserted during 2nd bit → ser_valid drops next cycle (only 2–3 bits sent), done=1, pass=0.
- No verdict after frame → done=1, timeout=1, pass=0 exactly 9 cycles after first WAIT_RES cycle; fail counter = 1.
- Three consecutive fails → locked=1 for 64 cycles, start ignored throughout, ready=0; then ready=1, a pass attempt succeeds.
- Fail, fail, pass, fail → no lockout (counter cleared by pass); res_pass && res_fail same cycle → pass=0.
- Assert rstn low mid-SEND → ser_valid=0 immediately, all outputs at reset values, fail counter 0; fresh start transmits full code.

Source files
------------

// File: rtl/lock_code_tx.sv
// lock_code_tx: sends a parallel code word MSB-first over ser_valid/ser_data,
// waits for the checker's pass/fail verdict (with timeout), reports the
// outcome on done/pass/timeout, and locks out after MAX_FAILS failed attempts.
//
// Ports:
//   clk, rstn           clock (rising edge), async active-low reset
//   code_in, start      code word and send request (taken when start && ready)
//   ready               high only while idle
//   ser_valid, ser_data serial frame toward the checker, MSB first
//   res_pass, res_fail  checker verdict pulses
//   done, pass, timeout one-cycle attempt report
//   locked              high for the whole lockout period
module lock_code_tx #(
    parameter int CODE_W      = 4,
    parameter int GAP         = 2,
    parameter int TIMEOUT     = 8,
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [CODE_W-1:0] code_in,
    input  logic              start,
    output logic              ready,
    output logic              ser_valid,
    output logic              ser_data,
    input  logic              res_pass,
    input  logic              res_fail,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic              locked
);

    localparam int IW  = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam int FW  = $clog2(MAX_FAILS + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int GW  = $clog2(GAP + 1);
    localparam int LW  = $clog2(LOCK_CYCLES + 1);
    localparam int CW0 = (TW > GW) ? TW : GW;
    localparam int CW  = (CW0 > LW) ? CW0 : LW;

    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
    localparam logic [FW-1:0] FAIL_MAX  = FW'(MAX_FAILS);
    localparam logic [IW-1:0] BIT_TOP   = IW'(CODE_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_RES,
        S_GAP,
        S_LOCKOUT
    } state_t;

    state_t            state_q, state_d;
    logic [CODE_W-1:0] shreg_q, shreg_d;
    logic [IW-1:0]     bit_q, bit_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [FW-1:0]     fail_q, fail_d;
    logic              vpass_q, vpass_d;
    logic              vto_q, vto_d;
    logic [FW-1:0]     fail_sat;

    // Count a failed attempt without wrapping past MAX_FAILS.
    assign fail_sat = (fail_q == FAIL_MAX) ? fail_q : fail_q + FW'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            fail_q  <= '0;
            vpass_q <= 1'b0;
            vto_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            vpass_q <= vpass_d;
            vto_q   <= vto_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_d     = bit_q;
        cnt_d     = cnt_q;
        fail_d    = fail_q;
        vpass_d   = vpass_q;
        vto_d     = vto_q;
        ready     = 1'b0;
        ser_valid = 1'b0;
        ser_data  = 1'b0;
        done      = 1'b0;
        pass      = 1'b0;
        timeout   = 1'b0;
        locked    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    shreg_d = code_in;
                    bit_d   = BIT_TOP;
                    state_d = S_SEND;
                end
            end

            S_SEND: begin
                // The MSB of the shift register is always the current bit.
                ser_valid = 1'b1;
                ser_data  = shreg_q[CODE_W-1];
                shreg_d   = shreg_q << 1;
                bit_d     = bit_q - IW'(1);
                if (res_fail) begin
                    vpass_d = 1'b0;
                    vto_d   = 1'b0;
                    fail_d  = fail_sat;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else if (bit_q == '0) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_RES;
                end
            end

            S_WAIT_RES: begin
                cnt_d = cnt_q + CW'(1);
                // A simultaneous pass and fail counts as a fail.
                if (res_fail) begin
                    vpass_d = 1'b0;
                    vto_d   = 1'b0;
                    fail_d  = fail_sat;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else if (res_pass) begin
                    vpass_d = 1'b1;
                    vto_d   = 1'b0;
                    fail_d  = '0;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else if (cnt_q == TO_LAST) begin
                    vpass_d = 1'b0;
                    vto_d   = 1'b1;
                    fail_d  = fail_sat;
                    cnt_d   = '0;
                    state_d = S_GAP;
                end
            end

            S_GAP: begin
                done    = (cnt_q == '0);
                pass    = done & vpass_q;
                timeout = done & vto_q;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = (fail_q == FAIL_MAX) ? S_LOCKOUT : S_IDLE;
                end
            end

            S_LOCKOUT: begin
                locked = 1'b1;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LOCK_LAST) begin
                    cnt_d   = '0;
                    fail_d  = '0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
